// File: rtl/core_multi_cycle_counter_if.sv
// Control/status bundle between the register slave (master side) and the
// multi-channel cycle counter (slave side).
interface core_multi_cycle_counter_if #(
   parameter int NUM_CH        = 4,
   parameter int NUM_CYCLE_BIT = 32
);
   logic [NUM_CH-1:0]               i_run;
   logic [NUM_CH-1:0]               i_abort;
   logic [NUM_CH-1:0]               i_reload;
   logic [NUM_CH*NUM_CYCLE_BIT-1:0] i_num_cycle;
   logic [NUM_CH-1:0]               i_done_clr;
   logic [NUM_CH-1:0]               o_idle;
   logic [NUM_CH-1:0]               o_running;
   logic [NUM_CH-1:0]               o_done;
   logic [NUM_CH-1:0]               o_tick;
   logic [NUM_CH*NUM_CYCLE_BIT-1:0] o_cnt;
   logic                            o_any_done;

   modport master (
      output i_run, i_abort, i_reload, i_num_cycle, i_done_clr,
      input  o_idle, o_running, o_done, o_tick, o_cnt, o_any_done
   );

   modport slave (
      input  i_run, i_abort, i_reload, i_num_cycle, i_done_clr,
      output o_idle, o_running, o_done, o_tick, o_cnt, o_any_done
   );
endinterface

// File: rtl/core_multi_cycle_counter.sv
// Multi-channel IDLE/RUNNING/DONE cycle counter with one-shot/periodic modes.
// Optional: define CORE_CYCLE_CNT_RETRIGGER_EN to let i_run restart a running channel.
module core_multi_cycle_counter #(
   parameter int NUM_CYCLE_BIT = 32,
   parameter int NUM_CH        = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   core_multi_cycle_counter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [NUM_CYCLE_BIT-1:0] ONE = NUM_CYCLE_BIT'(1);

   logic [NUM_CH-1:0]               idle_vec;
   logic [NUM_CH-1:0]               running_vec;
   logic [NUM_CH-1:0]               done_vec;
   logic [NUM_CH-1:0]               tick_vec;
   logic [NUM_CH*NUM_CYCLE_BIT-1:0] cnt_vec;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      state_t                   state_q, state_d;
      logic [NUM_CYCLE_BIT-1:0] cnt_q, cnt_d;
      logic [NUM_CYCLE_BIT-1:0] num_q, num_d;
      logic                     reload_q, reload_d;
      logic                     tick_q, tick_d;
      logic [NUM_CYCLE_BIT-1:0] num_in;
      logic                     run_ok;
      logic                     last;

      assign num_in = bus.i_num_cycle[k*NUM_CYCLE_BIT +: NUM_CYCLE_BIT];
      assign run_ok = bus.i_run[k] && (num_in != '0);
      // num_q is never 0 while RUNNING, so num_q-1 cannot underflow here
      assign last   = (cnt_q == (num_q - ONE));

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            num_q    <= '0;
            reload_q <= 1'b0;
            tick_q   <= 1'b0;
         end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            reload_q <= reload_d;
            tick_q   <= tick_d;
         end
      end

      always_comb begin
         state_d  = state_q;
         cnt_d    = cnt_q;
         num_d    = num_q;
         reload_d = reload_q;
         tick_d   = 1'b0;
         case (state_q)
            IDLE: begin
               if (run_ok) begin
                  state_d  = RUNNING;
                  cnt_d    = '0;
                  num_d    = num_in;
                  reload_d = bus.i_reload[k];
               end
            end
            RUNNING: begin
               if (bus.i_abort[k]) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
`ifdef CORE_CYCLE_CNT_RETRIGGER_EN
               else if (bus.i_run[k]) begin
                  // restart abandons the current period without a tick
                  if (run_ok) begin
                     cnt_d    = '0;
                     num_d    = num_in;
                     reload_d = bus.i_reload[k];
                  end else begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end
               end
`endif
               else if (last) begin
                  tick_d = 1'b1;
                  if (reload_q) cnt_d = '0;
                  else          state_d = DONE;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            DONE: begin
               if (bus.i_abort[k]) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (run_ok) begin
                  state_d  = RUNNING;
                  cnt_d    = '0;
                  num_d    = num_in;
                  reload_d = bus.i_reload[k];
               end else if (bus.i_done_clr[k]) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      assign idle_vec[k]    = (state_q == IDLE);
      assign running_vec[k] = (state_q == RUNNING);
      assign done_vec[k]    = (state_q == DONE);
      assign tick_vec[k]    = tick_q;
      assign cnt_vec[k*NUM_CYCLE_BIT +: NUM_CYCLE_BIT] = cnt_q;
   end

   assign bus.o_idle     = idle_vec;
   assign bus.o_running  = running_vec;
   assign bus.o_done     = done_vec;
   assign bus.o_tick     = tick_vec;
   assign bus.o_cnt      = cnt_vec;
   assign bus.o_any_done = |done_vec;

endmodule

// File: tb/tb_core_multi_cycle_counter.sv
// Randomised and directed bench for core_multi_cycle_counter against a
// start-time based reference model.
module tb_core_multi_cycle_counter;
   localparam int NCH = 4;
   localparam int W   = 32;
   localparam int VW  = 4*NCH + 1 + NCH*W;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   core_multi_cycle_counter_if #(.NUM_CH(NCH), .NUM_CYCLE_BIT(W)) dif();
   core_multi_cycle_counter_if #(.NUM_CH(1),   .NUM_CYCLE_BIT(4)) sif();

   core_multi_cycle_counter #(.NUM_CYCLE_BIT(W), .NUM_CH(NCH)) dut (
      .clk(clk), .reset(reset), .bus(dif));
   core_multi_cycle_counter #(.NUM_CYCLE_BIT(4), .NUM_CH(1)) dut_s (
      .clk(clk), .reset(reset), .bus(sif));

   always #5 clk = ~clk;

   // Reference model: a channel is either inactive or timing a run started at m_start.
   bit     m_act   [NCH];
   longint m_start [NCH];
   longint m_n     [NCH];
   bit     m_per   [NCH];
   longint cyc = 0;

   function automatic void m_eval(input int k, input longint c, output bit idl,
                                  output bit run, output bit dn, output bit tk,
                                  output longint cn);
      longint e;
      idl = 0; run = 0; dn = 0; tk = 0; cn = 0;
      if (!m_act[k]) idl = 1;
      else begin
         e = c - m_start[k];
         if (!m_per[k] && e >= m_n[k]) begin
            dn = 1; cn = m_n[k] - 1; tk = (e == m_n[k]);
         end else begin
            run = 1; cn = e % m_n[k]; tk = (e > 0) && (e % m_n[k] == 0);
         end
      end
   endfunction

   function automatic void m_clear();
      for (int k = 0; k < NCH; k++) m_act[k] = 0;
   endfunction

   function automatic void m_edge();
      bit pi, pr, pd, pt;
      longint pc, n;
      for (int k = 0; k < NCH; k++) begin
         m_eval(k, cyc, pi, pr, pd, pt, pc);
         n = longint'(dif.i_num_cycle[k*W +: W]);
`ifdef CORE_CYCLE_CNT_RETRIGGER_EN
         if (dif.i_abort[k] && !pi) m_act[k] = 0;
         else if (dif.i_run[k] && n != 0) begin
            m_act[k] = 1; m_start[k] = cyc + 1; m_n[k] = n; m_per[k] = dif.i_reload[k];
         end else if (dif.i_run[k] && pr) m_act[k] = 0;
         else if (dif.i_done_clr[k] && pd) m_act[k] = 0;
`else
         if (dif.i_abort[k] && !pi) m_act[k] = 0;
         else if (dif.i_run[k] && n != 0 && !pr) begin
            m_act[k] = 1; m_start[k] = cyc + 1; m_n[k] = n; m_per[k] = dif.i_reload[k];
         end else if (dif.i_done_clr[k] && pd) m_act[k] = 0;
`endif
      end
      cyc++;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [NCH-1:0]   ei, er, ed, et;
      logic [NCH*W-1:0] ec;
      bit i1, r1, d1, t1;
      longint cn;
      for (int k = 0; k < NCH; k++) begin
         m_eval(k, cyc, i1, r1, d1, t1, cn);
         ei[k] = i1; er[k] = r1; ed[k] = d1; et[k] = t1;
         ec[k*W +: W] = cn[W-1:0];
      end
      return {ei, er, ed, et, |ed, ec};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {dif.o_idle, dif.o_running, dif.o_done, dif.o_tick, dif.o_any_done, dif.o_cnt};
   endfunction

   task automatic step();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic clear_pulses();
      dif.i_run = '0; dif.i_abort = '0; dif.i_done_clr = '0;
      sif.i_run = '0; sif.i_abort = '0; sif.i_done_clr = '0;
   endtask

   task automatic start_ch(input int k, input logic [W-1:0] n, input bit per);
      dif.i_num_cycle[k*W +: W] = n;
      dif.i_reload[k] = per;
      dif.i_run[k] = 1'b1;
   endtask

   task automatic idle_all();
      clear_pulses();
      dif.i_abort = '1; sif.i_abort = '1;
      step();
      clear_pulses();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_pulses();
      dif.i_reload = '0; dif.i_num_cycle = '0;
      sif.i_reload = '0; sif.i_num_cycle = '0;
      m_clear();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dif.o_idle !== 4'hF) begin
         errors++; $display("FAIL reset_idle got=%h exp=f", dif.o_idle);
      end
      checks++;
      if ({dif.o_running, dif.o_done, dif.o_tick, dif.o_any_done} !== 13'h0 || dif.o_cnt !== 128'h0) begin
         errors++; $display("FAIL reset_outputs got=%h/%h/%h/%b cnt=%h exp=0", dif.o_running,
                            dif.o_done, dif.o_tick, dif.o_any_done, dif.o_cnt);
      end
      checks++;
      if (sif.o_idle !== 1'b1 || sif.o_cnt !== 4'h0) begin
         errors++; $display("FAIL reset_small got=%b/%h exp=1/0", sif.o_idle, sif.o_cnt);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++; $display("FAIL reset_model got=%h exp=%h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_oneshot();
      clear_pulses();
      start_ch(0, 32'd5, 1'b0);
      step(); clear_pulses();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (dif.o_running[0] !== 1'b1 || dif.o_cnt[0 +: W] !== 32'(i)) begin
            errors++; $display("FAIL oneshot_count run=%b cnt=%0d exp run=1 cnt=%0d",
                               dif.o_running[0], dif.o_cnt[0 +: W], i);
         end
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL oneshot_model got=%h exp=%h", dut_vec(), exp_vec());
         end
         step();
      end
      checks++;
      if ({dif.o_done[0], dif.o_tick[0], dif.o_any_done, dif.o_running[0]} !== 4'b1110) begin
         errors++; $display("FAIL oneshot_done done/tick/any/run got=%b%b%b%b exp=1110",
                            dif.o_done[0], dif.o_tick[0], dif.o_any_done, dif.o_running[0]);
      end
      dif.i_done_clr[0] = 1'b1;
      step(); clear_pulses();
      checks++;
      if (dif.o_idle[0] !== 1'b1 || dif.o_any_done !== 1'b0) begin
         errors++; $display("FAIL oneshot_clr idle=%b any=%b exp=1/0", dif.o_idle[0], dif.o_any_done);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++; $display("FAIL oneshot_clr_model got=%h exp=%h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_periodic();
      clear_pulses();
      start_ch(1, 32'd3, 1'b1);
      step(); clear_pulses();
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (dif.o_tick[1] !== ((i == 3) || (i == 6) || (i == 9)) || dif.o_done[1] !== 1'b0
             || dif.o_cnt[W +: W] !== 32'(i % 3)) begin
            errors++; $display("FAIL periodic_tick i=%0d tick=%b done=%b cnt=%0d exp cnt=%0d",
                               i, dif.o_tick[1], dif.o_done[1], dif.o_cnt[W +: W], i % 3);
         end
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL periodic_model got=%h exp=%h", dut_vec(), exp_vec());
         end
         step();
      end
      dif.i_abort[1] = 1'b1;
      step(); clear_pulses();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dif.o_idle[1] !== 1'b1 || dif.o_tick[1] !== 1'b0 || dif.o_cnt[W +: W] !== 32'h0) begin
            errors++; $display("FAIL periodic_abort idle=%b tick=%b cnt=%0d exp 1/0/0",
                               dif.o_idle[1], dif.o_tick[1], dif.o_cnt[W +: W]);
         end
         step();
      end
   endtask

   task automatic test_boundaries();
      idle_all();
      start_ch(3, 32'd1, 1'b0);
      step(); clear_pulses();
      checks++;
      if (dif.o_running[3] !== 1'b1 || dif.o_cnt[3*W +: W] !== 32'h0) begin
         errors++; $display("FAIL n1_run run=%b cnt=%0d exp 1/0", dif.o_running[3], dif.o_cnt[3*W +: W]);
      end
      step();
      checks++;
      if (dif.o_done[3] !== 1'b1 || dif.o_tick[3] !== 1'b1) begin
         errors++; $display("FAIL n1_done done=%b tick=%b exp 1/1", dif.o_done[3], dif.o_tick[3]);
      end
      start_ch(2, 32'd0, 1'b0);
      step(); clear_pulses();
      checks++;
      if (dif.o_idle[2] !== 1'b1 || dif.o_tick[2] !== 1'b0) begin
         errors++; $display("FAIL n0_ignored idle=%b tick=%b exp 1/0", dif.o_idle[2], dif.o_tick[2]);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++; $display("FAIL n0_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      start_ch(0, 32'hFFFF_FFFF, 1'b0);
      step(); clear_pulses();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (dif.o_running[0] !== 1'b1 || dif.o_cnt[0 +: W] !== 32'(i)) begin
            errors++; $display("FAIL nmax_count run=%b cnt=%h exp cnt=%h",
                               dif.o_running[0], dif.o_cnt[0 +: W], i);
         end
         step();
      end
      // narrow instance runs all the way to its largest period
      sif.i_num_cycle = 4'hF; sif.i_reload = 1'b0; sif.i_run = 1'b1;
      step(); clear_pulses();
      for (int i = 0; i < 15; i++) begin
         checks++;
         if (sif.o_running !== 1'b1 || sif.o_cnt !== 4'(i)) begin
            errors++; $display("FAIL small_max_count i=%0d run=%b cnt=%h", i, sif.o_running, sif.o_cnt);
         end
         step();
      end
      checks++;
      if (sif.o_done !== 1'b1 || sif.o_tick !== 1'b1 || sif.o_cnt !== 4'hE) begin
         errors++; $display("FAIL small_max_done done=%b tick=%b cnt=%h exp 1/1/e",
                            sif.o_done, sif.o_tick, sif.o_cnt);
      end
      step();
      checks++;
      if (sif.o_done !== 1'b1 || sif.o_tick !== 1'b0 || sif.o_cnt !== 4'hE) begin
         errors++; $display("FAIL small_max_hold done=%b tick=%b cnt=%h exp 1/0/e",
                            sif.o_done, sif.o_tick, sif.o_cnt);
      end
      idle_all();
   endtask

   task automatic test_conflicts();
      idle_all();
      start_ch(0, 32'd2, 1'b0);
      step(); clear_pulses(); step(); step();
      checks++;
      if (dif.o_done[0] !== 1'b1) begin
         errors++; $display("FAIL conf_setup done=%b exp 1", dif.o_done[0]);
      end
      start_ch(0, 32'd2, 1'b0); dif.i_abort[0] = 1'b1;
      step(); clear_pulses();
      checks++;
      if (dif.o_idle[0] !== 1'b1 || dif.o_running[0] !== 1'b0) begin
         errors++; $display("FAIL abort_vs_run idle=%b run=%b exp 1/0", dif.o_idle[0], dif.o_running[0]);
      end
      start_ch(0, 32'd2, 1'b0);
      step(); clear_pulses(); step(); step();
      start_ch(0, 32'd3, 1'b0); dif.i_done_clr[0] = 1'b1;
      step(); clear_pulses();
      checks++;
      if (dif.o_running[0] !== 1'b1 || dif.o_cnt[0 +: W] !== 32'h0) begin
         errors++; $display("FAIL run_vs_clr run=%b cnt=%0d exp 1/0", dif.o_running[0], dif.o_cnt[0 +: W]);
      end
      step(); step();
      checks++;
      if (dif.o_cnt[0 +: W] !== 32'd2) begin
         errors++; $display("FAIL abort_last_setup cnt=%0d exp 2", dif.o_cnt[0 +: W]);
      end
      dif.i_abort[0] = 1'b1;
      step(); clear_pulses();
      checks++;
      if (dif.o_idle[0] !== 1'b1 || dif.o_tick[0] !== 1'b0 || dif.o_done[0] !== 1'b0) begin
         errors++; $display("FAIL abort_last idle=%b tick=%b done=%b exp 1/0/0",
                            dif.o_idle[0], dif.o_tick[0], dif.o_done[0]);
      end
      idle_all();
      for (int k = 0; k < NCH; k++) start_ch(k, 32'(k + 2), 1'b0);
      step(); clear_pulses();
      for (int i = 0; i < 8; i++) begin
         logic [NCH-1:0] ed, et;
         for (int k = 0; k < NCH; k++) begin
            ed[k] = (i >= k + 2);
            et[k] = (i == k + 2);
         end
         checks++;
         if (dif.o_done !== ed || dif.o_tick !== et) begin
            errors++; $display("FAIL all_ch i=%0d done=%b tick=%b exp %b/%b",
                               i, dif.o_done, dif.o_tick, ed, et);
         end
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL all_ch_model got=%h exp=%h", dut_vec(), exp_vec());
         end
         step();
      end
      idle_all();
   endtask

   task automatic test_retrigger();
      int steps;
      int exp_steps;
      logic [W-1:0] exp_cnt0, exp_done_cnt;
`ifdef CORE_CYCLE_CNT_RETRIGGER_EN
      exp_steps = 3; exp_cnt0 = 32'd0; exp_done_cnt = 32'd2;
`else
      exp_steps = 5; exp_cnt0 = 32'd5; exp_done_cnt = 32'd9;
`endif
      idle_all();
      start_ch(0, 32'd10, 1'b0);
      step(); clear_pulses();
      repeat (4) step();
      checks++;
      if (dif.o_cnt[0 +: W] !== 32'd4) begin
         errors++; $display("FAIL retrig_setup cnt=%0d exp 4", dif.o_cnt[0 +: W]);
      end
      start_ch(0, 32'd3, 1'b0);
      step(); clear_pulses();
      checks++;
      if (dif.o_cnt[0 +: W] !== exp_cnt0 || dif.o_running[0] !== 1'b1) begin
         errors++; $display("FAIL retrig_cnt cnt=%0d run=%b exp %0d/1",
                            dif.o_cnt[0 +: W], dif.o_running[0], exp_cnt0);
      end
      steps = 0;
      while (dif.o_done[0] !== 1'b1 && steps < 20) begin
         checks++;
         if (dif.o_tick[0] !== 1'b0 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL retrig_run tick=%b got=%h exp=%h", dif.o_tick[0], dut_vec(), exp_vec());
         end
         step();
         steps++;
      end
      checks++;
      if (steps != exp_steps || dif.o_tick[0] !== 1'b1 || dif.o_cnt[0 +: W] !== exp_done_cnt) begin
         errors++; $display("FAIL retrig_done steps=%0d tick=%b cnt=%0d exp %0d/1/%0d",
                            steps, dif.o_tick[0], dif.o_cnt[0 +: W], exp_steps, exp_done_cnt);
      end
      idle_all();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NCH; k++) begin
            dif.i_run[k]      = ($urandom_range(0, 3) == 0);
            dif.i_abort[k]    = ($urandom_range(0, 15) == 0);
            dif.i_done_clr[k] = ($urandom_range(0, 3) == 0);
            dif.i_reload[k]   = ($urandom_range(0, 1) == 1);
            dif.i_num_cycle[k*W +: W] = $urandom_range(0, 5);
         end
         step();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
      end
      clear_pulses();
   endtask

   task automatic test_midreset();
      idle_all();
      start_ch(2, 32'd20, 1'b0);
      start_ch(0, 32'd3, 1'b1);
      step(); clear_pulses();
      repeat (7) step();
      checks++;
      if (dif.o_cnt[2*W +: W] !== 32'd7) begin
         errors++; $display("FAIL midreset_setup cnt=%0d exp 7", dif.o_cnt[2*W +: W]);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (dif.o_idle !== 4'hF || dif.o_running !== 4'h0 || dif.o_done !== 4'h0 ||
          dif.o_tick !== 4'h0 || dif.o_cnt !== 128'h0 || dif.o_any_done !== 1'b0) begin
         errors++; $display("FAIL midreset_async idle=%h run=%h done=%h tick=%h cnt=%h any=%b",
                            dif.o_idle, dif.o_running, dif.o_done, dif.o_tick, dif.o_cnt, dif.o_any_done);
      end
      m_clear();
      #1 reset = 1'b0;
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++; $display("FAIL midreset_after got=%h exp=%h", dut_vec(), exp_vec());
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_boundaries();
      test_conflicts();
      test_retrigger();
      test_random();
      test_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
